// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing generator: legacy 256x192 raster
// defaults, the window decode helper and the adjustment sign-extender.
package vtg_pkg;

    // Legacy 256x192 screen timing.
    localparam int VTG_H_TOTAL     = 384;
    localparam int VTG_H_ACT_START = 16;
    localparam int VTG_H_ACT_END   = 272;
    localparam int VTG_HS_START    = 311;
    localparam int VTG_HS_END      = 342;
    localparam int VTG_V_TOTAL     = 263;
    localparam int VTG_V_ACT_START = 16;
    localparam int VTG_V_ACT_END   = 208;
    localparam int VTG_VS_START    = 235;
    localparam int VTG_VS_END      = 242;
    localparam int VTG_CNT_W       = 9;
    localparam int VTG_RGB_W       = 12;

    // Range of the 4-bit signed screen-position adjustment.
    localparam int VTG_ADJ_MIN = -8;
    localparam int VTG_ADJ_MAX = 7;

    // Widest counter the helpers below can handle; narrower counters are
    // zero-extended into this type before comparison.
    localparam int VTG_MAX_W = 16;
    typedef logic [VTG_MAX_W-1:0] vtg_cnt_t;

    // Unsigned half-open window test: start <= cnt < win_end.
    function automatic logic window_in(input vtg_cnt_t cnt,
                                       input vtg_cnt_t win_start,
                                       input vtg_cnt_t win_end);
        return (cnt >= win_start) && (cnt < win_end);
    endfunction

    // Sign-extend a 4-bit adjustment; callers truncate to their counter width,
    // which turns negative shifts into modular subtraction.
    function automatic vtg_cnt_t sext_adj(input logic [3:0] adj);
        return {{(VTG_MAX_W-4){adj[3]}}, adj};
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping counter with enable, combinational wrap strobe,
// and registered blank/sync flags decoded from the value being loaded so the
// flags line up with the counter they describe.
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int TOTAL      = VTG_H_TOTAL,
    parameter int ACT_START  = VTG_H_ACT_START,
    parameter int ACT_END    = VTG_H_ACT_END,
    parameter int SYNC_START = VTG_HS_START,
    parameter int SYNC_END   = VTG_HS_END,
    parameter int CNT_W      = VTG_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_adj,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_blank,
    output logic             o_sync_n
);

    localparam logic [CNT_W-1:0] LP_LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] LP_SYNC_START = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] LP_SYNC_END   = CNT_W'(SYNC_END);

    // The sync window has to stay inside the raster and clear of the active
    // area for every possible adjustment, otherwise the modular window math
    // below would produce a split or overlapping window.
    generate
        if (CNT_W > VTG_MAX_W || TOTAL > (2 ** CNT_W) ||
            ACT_START >= ACT_END || ACT_END > TOTAL ||
            SYNC_START + VTG_ADJ_MIN < 0 || SYNC_END + VTG_ADJ_MAX > TOTAL ||
            SYNC_START >= SYNC_END ||
            (SYNC_START + VTG_ADJ_MIN < ACT_END &&
             SYNC_END + VTG_ADJ_MAX > ACT_START)) begin : g_bad_timing
            $error("vtg_axis_counter: timing window out of range or overlapping");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_blank;
    logic             r_sync_n;
    logic             w_at_last;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_sync_lo;
    logic [CNT_W-1:0] w_sync_hi;

    assign w_at_last  = (r_cnt == LP_LAST);
    assign w_cnt_next = w_at_last ? '0 : r_cnt + 1'b1;
    assign w_sync_lo  = LP_SYNC_START + i_adj;
    assign w_sync_hi  = LP_SYNC_END + i_adj;

    assign o_wrap   = i_en & w_at_last;
    assign o_cnt    = r_cnt;
    assign o_blank  = r_blank;
    assign o_sync_n = r_sync_n;

    // Advance the count and load the flags for the new count on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_blank  <= 1'b1;
            r_sync_n <= 1'b1;
        end else if (i_en) begin
            r_cnt    <= w_cnt_next;
            r_blank  <= ~window_in(vtg_cnt_t'(w_cnt_next),
                                   vtg_cnt_t'(ACT_START),
                                   vtg_cnt_t'(ACT_END));
            r_sync_n <= ~window_in(vtg_cnt_t'(w_cnt_next),
                                   vtg_cnt_t'(w_sync_lo),
                                   vtg_cnt_t'(w_sync_hi));
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with RGB blanking, clocked from the
// system clock and advanced by a pixel clock-enable.
// Optional feature: define VTG_ADJUST_EN to latch h_adj/v_adj at each frame
// wrap and shift the sync windows; otherwise the inputs are ignored.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_TOTAL     = VTG_H_TOTAL,
    parameter int H_ACT_START = VTG_H_ACT_START,
    parameter int H_ACT_END   = VTG_H_ACT_END,
    parameter int HS_START    = VTG_HS_START,
    parameter int HS_END      = VTG_HS_END,
    parameter int V_TOTAL     = VTG_V_TOTAL,
    parameter int V_ACT_START = VTG_V_ACT_START,
    parameter int V_ACT_END   = VTG_V_ACT_END,
    parameter int VS_START    = VTG_VS_START,
    parameter int VS_END      = VTG_VS_END,
    parameter int CNT_W       = VTG_CNT_W,
    parameter int RGB_W       = VTG_RGB_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [3:0]       h_adj,
    input  logic [3:0]       v_adj,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             line_start,
    output logic             frame_start,
    output logic [RGB_W-1:0] rgb_out
);

    localparam logic [CNT_W-1:0] LP_H_ACT_START = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] LP_V_ACT_START = CNT_W'(V_ACT_START);

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_h_wrap;
    logic             w_v_en;
    logic             w_frame_wrap;
    logic [CNT_W-1:0] w_ha_next;
    logic [CNT_W-1:0] w_va_next;
    logic             w_blank_now;
    logic [RGB_W-1:0] w_rgb_masked;

    logic             r_line_start;
    logic             r_frame_start;
    logic [RGB_W-1:0] r_rgb;

    // The vertical axis only steps on a horizontal wrap, so its wrap strobe
    // already implies the end of the last line of the frame.
    assign w_v_en = w_h_wrap;

`ifdef VTG_ADJUST_EN
    logic [CNT_W-1:0] r_ha;
    logic [CNT_W-1:0] r_va;

    // New adjustments take effect together with the first pixel of the frame
    // so a change made mid-frame cannot tear the picture.
    assign w_ha_next = w_frame_wrap ? CNT_W'(sext_adj(h_adj)) : r_ha;
    assign w_va_next = w_frame_wrap ? CNT_W'(sext_adj(v_adj)) : r_va;

    // Hold the adjustments that apply to the current frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ha <= '0;
            r_va <= '0;
        end else begin
            r_ha <= w_ha_next;
            r_va <= w_va_next;
        end
    end
`else
    logic w_unused_adj;

    assign w_unused_adj = ^{h_adj, v_adj};
    assign w_ha_next    = '0;
    assign w_va_next    = '0;
`endif

    vtg_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACT_START  (H_ACT_START),
        .ACT_END    (H_ACT_END),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END),
        .CNT_W      (CNT_W)
    ) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .i_en     (ce_pix),
        .i_adj    (w_ha_next),
        .o_cnt    (w_hcnt),
        .o_wrap   (w_h_wrap),
        .o_blank  (hblank),
        .o_sync_n (hsync_n)
    );

    vtg_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACT_START  (V_ACT_START),
        .ACT_END    (V_ACT_END),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END),
        .CNT_W      (CNT_W)
    ) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_v_en),
        .i_adj    (w_va_next),
        .o_cnt    (w_vcnt),
        .o_wrap   (w_frame_wrap),
        .o_blank  (vblank),
        .o_sync_n (vsync_n)
    );

    // Positions are relative to the first active pixel/line; values before
    // the active start wrap around modulo 2^CNT_W.
    assign hpos = w_hcnt - LP_H_ACT_START;
    assign vpos = w_vcnt - LP_V_ACT_START;

    // The pixel arriving now belongs to the position whose flags are still
    // registered, so blanking uses the pre-update flags.
    assign w_blank_now = hblank | vblank;

    genvar gi;
    generate
        for (gi = 0; gi < RGB_W; gi++) begin : g_rgb_mask
            assign w_rgb_masked[gi] = rgb_in[gi] & ~w_blank_now;
        end
    endgenerate

    // Strobes follow the wrapping ce by one clk; RGB is captured once per ce
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_frame_wrap;
            if (ce_pix) begin
                r_rgb <= w_rgb_masked;
            end
        end
    end

    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign rgb_out     = r_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a shrunken raster instance (full frames fit in
// the run) and a legacy-default instance share one randomised stimulus
// stream; both are compared every clk against a position model computed
// from the count of pixel enables since reset.
module tb_video_timing_gen;

    localparam int RGB_W = 12;
    localparam int S_W   = 6;
    localparam int D_W   = 9;

    typedef struct packed {
        int ht; int has; int hae; int hss; int hse;
        int vt; int vas; int vae; int vss; int vse;
        int w;
    } tim_t;

    typedef struct packed {
        int hpos; int vpos;
        bit hblank; bit vblank; bit hsync_n; bit vsync_n;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ce_pix = 1'b0;
    logic [3:0]       h_adj = 4'h0;
    logic [3:0]       v_adj = 4'h0;
    logic [RGB_W-1:0] rgb_in = '0;

    logic [S_W-1:0]   s_hpos, s_vpos;
    logic             s_hblank, s_vblank, s_hsync_n, s_vsync_n;
    logic             s_line_start, s_frame_start;
    logic [RGB_W-1:0] s_rgb_out;

    logic [D_W-1:0]   d_hpos, d_vpos;
    logic             d_hblank, d_vblank, d_hsync_n, d_vsync_n;
    logic             d_line_start, d_frame_start;
    logic [RGB_W-1:0] d_rgb_out;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_TOTAL(48), .H_ACT_START(4), .H_ACT_END(24), .HS_START(32), .HS_END(38),
        .V_TOTAL(30), .V_ACT_START(2), .V_ACT_END(12), .VS_START(20), .VS_END(22),
        .CNT_W(S_W), .RGB_W(RGB_W)
    ) dut_small (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .h_adj(h_adj), .v_adj(v_adj),
        .rgb_in(rgb_in), .hpos(s_hpos), .vpos(s_vpos), .hblank(s_hblank),
        .vblank(s_vblank), .hsync_n(s_hsync_n), .vsync_n(s_vsync_n),
        .line_start(s_line_start), .frame_start(s_frame_start), .rgb_out(s_rgb_out)
    );

    video_timing_gen dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .h_adj(h_adj), .v_adj(v_adj),
        .rgb_in(rgb_in), .hpos(d_hpos), .vpos(d_vpos), .hblank(d_hblank),
        .vblank(d_vblank), .hsync_n(d_hsync_n), .vsync_n(d_vsync_n),
        .line_start(d_line_start), .frame_start(d_frame_start), .rgb_out(d_rgb_out)
    );

    tim_t st, dt;
    int   n;
    int   s_ha, s_va, d_ha, d_va;
    logic [RGB_W-1:0] s_rgb_exp, d_rgb_exp;
    bit   s_ls, s_fs, d_ls, d_fs;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Expected flags and positions for the n-th pixel enable since reset.
    function automatic exp_t decode(input tim_t t, input int cnt, input int ha, input int va);
        exp_t e;
        int h, v, m;
        h = cnt % t.ht;
        v = (cnt / t.ht) % t.vt;
        m = 1 << t.w;
        e.hpos    = (h - t.has + m) % m;
        e.vpos    = (v - t.vas + m) % m;
        e.hblank  = !(h >= t.has && h < t.hae);
        e.vblank  = !(v >= t.vas && v < t.vae);
        e.hsync_n = !(h >= t.hss + ha && h < t.hse + ha);
        e.vsync_n = !(v >= t.vss + va && v < t.vse + va);
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (n=%0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit ce, input logic [RGB_W-1:0] rgb,
                                input logic [3:0] ha_in, input logic [3:0] va_in);
        exp_t es, ed;
        if (rst) begin
            n = 0;
            s_ha = 0; s_va = 0; d_ha = 0; d_va = 0;
            s_rgb_exp = '0; d_rgb_exp = '0;
            s_ls = 0; s_fs = 0; d_ls = 0; d_fs = 0;
        end else if (ce) begin
            es = decode(st, n, s_ha, s_va);
            ed = decode(dt, n, d_ha, d_va);
            s_rgb_exp = (es.hblank || es.vblank) ? '0 : rgb;
            d_rgb_exp = (ed.hblank || ed.vblank) ? '0 : rgb;
            n++;
            s_ls = (n % st.ht) == 0;
            s_fs = (n % (st.ht * st.vt)) == 0;
            d_ls = (n % dt.ht) == 0;
            d_fs = (n % (dt.ht * dt.vt)) == 0;
`ifdef VTG_ADJUST_EN
            if (s_fs) begin
                s_ha = int'($signed(ha_in));
                s_va = int'($signed(va_in));
            end
            if (d_fs) begin
                d_ha = int'($signed(ha_in));
                d_va = int'($signed(va_in));
            end
`else
            if (ha_in === 4'hx || va_in === 4'hx) begin
                s_ha = 0;
            end
`endif
        end else begin
            s_ls = 0; s_fs = 0; d_ls = 0; d_fs = 0;
        end
    endtask

    task automatic check_all();
        exp_t es, ed;
        es = decode(st, n, s_ha, s_va);
        ed = decode(dt, n, d_ha, d_va);
        check_val("s_hpos",        32'(s_hpos),       32'(es.hpos));
        check_val("s_vpos",        32'(s_vpos),       32'(es.vpos));
        check_val("s_hblank",      32'(s_hblank),     32'(es.hblank));
        check_val("s_vblank",      32'(s_vblank),     32'(es.vblank));
        check_val("s_hsync_n",     32'(s_hsync_n),    32'(es.hsync_n));
        check_val("s_vsync_n",     32'(s_vsync_n),    32'(es.vsync_n));
        check_val("s_line_start",  32'(s_line_start), 32'(s_ls));
        check_val("s_frame_start", 32'(s_frame_start),32'(s_fs));
        check_val("s_rgb_out",     32'(s_rgb_out),    32'(s_rgb_exp));
        check_val("d_hpos",        32'(d_hpos),       32'(ed.hpos));
        check_val("d_vpos",        32'(d_vpos),       32'(ed.vpos));
        check_val("d_hblank",      32'(d_hblank),     32'(ed.hblank));
        check_val("d_vblank",      32'(d_vblank),     32'(ed.vblank));
        check_val("d_hsync_n",     32'(d_hsync_n),    32'(ed.hsync_n));
        check_val("d_vsync_n",     32'(d_vsync_n),    32'(ed.vsync_n));
        check_val("d_line_start",  32'(d_line_start), 32'(d_ls));
        check_val("d_frame_start", 32'(d_frame_start),32'(d_fs));
        check_val("d_rgb_out",     32'(d_rgb_out),    32'(d_rgb_exp));
    endtask

    // One clk: drive at the falling edge, model at the rising edge, compare
    // at the next falling edge.
    task automatic cycle(input bit rst, input bit ce, input logic [RGB_W-1:0] rgb,
                         input logic [3:0] ha_in, input logic [3:0] va_in);
        reset  = rst;
        ce_pix = ce;
        rgb_in = rgb;
        h_adj  = ha_in;
        v_adj  = va_in;
        @(posedge clk);
        model_update(rst, ce, rgb, ha_in, va_in);
        @(negedge clk);
        check_all();
    endtask

    task automatic report_phase(input string name, input int cycles);
        $display("phase %s: %0d clks, ce count %0d, %0d vectors so far", name, cycles, n, vec_cnt);
    endtask

    initial begin
        logic [3:0] ha_r, va_r;
        st = '{ht: 48, has: 4, hae: 24, hss: 32, hse: 38,
               vt: 30, vas: 2, vae: 12, vss: 20, vse: 22, w: S_W};
        dt = '{ht: 384, has: 16, hae: 272, hss: 311, hse: 342,
               vt: 263, vas: 16, vae: 208, vss: 235, vse: 242, w: D_W};
        n = 0;

        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 12'hFFF, 4'h0, 4'h0);
        report_phase("reset", 3);

        // Full-rate pixel enable with random pixels: two small frames.
        for (int i = 0; i < 2 * 48 * 30; i++)
            cycle(1'b0, 1'b1, RGB_W'($urandom), 4'h0, 4'h0);
        report_phase("full_rate", 2 * 48 * 30);

        // Constant pixel: output is either blanked or the held colour.
        for (int i = 0; i < 1500; i++)
            cycle(1'b0, 1'b1, 12'hABC, 4'h0, 4'h0);
        report_phase("rgb_hold", 1500);

        // hsync shifted left by 3 from mid-frame on; takes hold at frame wrap.
        for (int i = 0; i < 2 * 48 * 30 + 100; i++)
            cycle(1'b0, 1'b1, RGB_W'($urandom), 4'hD, 4'h0);
        report_phase("h_adj_m3", 2 * 48 * 30 + 100);

        // Pixel enable held low: everything frozen, strobes quiet.
        for (int i = 0; i < 1000; i++)
            cycle(1'b0, 1'b0, RGB_W'($urandom), 4'($urandom), 4'($urandom));
        report_phase("ce_low", 1000);

        // Random enable density and adjustments that change mid-frame.
        ha_r = 4'($urandom);
        va_r = 4'($urandom);
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) begin
                ha_r = 4'($urandom);
                va_r = 4'($urandom);
            end
            cycle(1'b0, ($urandom_range(0, 3) != 0), RGB_W'($urandom), ha_r, va_r);
        end
        report_phase("random", 4000);

        // Reset mid-frame with ce high, then resume.
        cycle(1'b1, 1'b1, 12'h5A5, 4'h3, 4'h2);
        report_phase("reset_mid_frame", 1);
        for (int i = 0; i < 300; i++)
            cycle(1'b0, 1'b1, RGB_W'($urandom), 4'h0, 4'h0);
        report_phase("after_reset", 300);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
